// File: rtl/flash_array_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_array_engine_if
// Purpose  : Command / data-stream bundle between SPI decoder and array engine.
// Revision : 1.0  initial release
// ============================================================================
interface flash_array_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 21
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_req,
        input  cmd_ready, rd_data, rd_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_req,
        output cmd_ready, rd_data, rd_valid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/flash_array_engine.sv
`default_nettype none
// ============================================================================
// Module   : flash_array_engine
// Purpose  : Flash array + page buffer; read stream, page load/commit,
//            sector/bulk erase, one word per cycle behind busy.
// Revision : 1.0  initial release
// ============================================================================
module flash_array_engine #(
    parameter int DATA_W       = 8,
    parameter int MEM_WORDS    = 2097152,
    parameter int PAGE_WORDS   = 256,
    parameter int SECTOR_WORDS = 65536,
    parameter int ADDR_W       = $clog2(MEM_WORDS)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    flash_array_engine_if.slave  bus
);
    localparam int PG_W = $clog2(PAGE_WORDS);

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_COMMIT = 3'd2;
    localparam logic [2:0] OP_SECTOR = 3'd3;
    localparam logic [2:0] OP_BULK   = 3'd4;
    localparam logic [2:0] OP_STOP   = 3'd7;

    localparam logic [ADDR_W-1:0] PG_MASK   = ~ADDR_W'(PAGE_WORDS - 1);
    localparam logic [ADDR_W-1:0] SEC_MASK  = ~ADDR_W'(SECTOR_WORDS - 1);
    localparam logic [ADDR_W-1:0] PG_LAST   = ADDR_W'(PAGE_WORDS - 1);
    localparam logic [ADDR_W-1:0] SEC_LAST  = ADDR_W'(SECTOR_WORDS - 1);
    localparam logic [ADDR_W-1:0] MEM_LAST  = ADDR_W'(MEM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PG_W-1:0]   IDX_ONE   = PG_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERASE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] pg_base;
    logic [PG_W-1:0]   pg_idx;
    logic              loaded;
    logic [ADDR_W-1:0] op_ptr;
    logic [ADDR_W-1:0] op_cnt;
    logic [ADDR_W-1:0] op_last;

    // The array is held inverted so that its zero power-on state reads as erased (all-ones).
    logic [DATA_W-1:0] mem_n  [MEM_WORDS];
    logic [DATA_W-1:0] pbuf   [PAGE_WORDS];
    logic [PAGE_WORDS-1:0] pvalid;

    logic              accept;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [PG_W-1:0]   cm_idx;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign cm_idx = op_cnt[PG_W-1:0];

    // Buffer words never written since the last load count as all-ones, so they leave the array untouched.
    always_comb begin
        mem_we      = (state == ST_COMMIT) || (state == ST_ERASE);
        mem_wdata_n = '0;
        if (state == ST_COMMIT) begin
            mem_wdata_n = pvalid[cm_idx] ? (mem_n[op_ptr] | ~pbuf[cm_idx]) : mem_n[op_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_n[op_ptr] <= mem_wdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.cmd_op == OP_LOAD) begin
            pvalid <= '0;
        end else if (!accept && state == ST_LOAD && bus.wr_valid) begin
            pvalid[pg_idx] <= 1'b1;
            pbuf[pg_idx]   <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rd_ptr        <= '0;
            pg_base       <= '0;
            pg_idx        <= '0;
            loaded        <= 1'b0;
            op_ptr        <= '0;
            op_cnt        <= '0;
            op_last       <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            if (accept) begin
                bus.rd_data <= '0;
                case (bus.cmd_op)
                    OP_READ: begin
                        state  <= ST_READ;
                        rd_ptr <= bus.cmd_addr;
                    end
                    OP_LOAD: begin
                        state   <= ST_LOAD;
                        pg_base <= bus.cmd_addr & PG_MASK;
                        pg_idx  <= bus.cmd_addr[PG_W-1:0];
                        loaded  <= 1'b1;
                    end
                    OP_COMMIT: begin
                        if (loaded) begin
                            state         <= ST_COMMIT;
                            op_ptr        <= pg_base;
                            op_cnt        <= '0;
                            op_last       <= PG_LAST;
                            bus.cmd_ready <= 1'b0;
                            bus.busy      <= 1'b1;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                    OP_SECTOR: begin
                        state         <= ST_ERASE;
                        op_ptr        <= bus.cmd_addr & SEC_MASK;
                        op_cnt        <= '0;
                        op_last       <= SEC_LAST;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                    OP_BULK: begin
                        state         <= ST_ERASE;
                        op_ptr        <= '0;
                        op_cnt        <= '0;
                        op_last       <= MEM_LAST;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                    OP_STOP: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bus.err <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    ST_READ: begin
                        if (bus.rd_req) begin
                            bus.rd_data  <= ~mem_n[rd_ptr];
                            bus.rd_valid <= 1'b1;
                            rd_ptr       <= rd_ptr + ADDR_ONE;
                        end
                    end
                    ST_LOAD: begin
                        if (bus.wr_valid) begin
                            pg_idx <= pg_idx + IDX_ONE;
                        end
                    end
                    ST_COMMIT, ST_ERASE: begin
                        op_ptr <= op_ptr + ADDR_ONE;
                        op_cnt <= op_cnt + ADDR_ONE;
                        if (op_cnt == op_last) begin
                            state         <= ST_IDLE;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.cmd_ready <= 1'b1;
                            if (state == ST_COMMIT) begin
                                loaded <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        bus.rd_data <= '0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_flash_array_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_array_engine
// Purpose  : Self-checking bench: vector table, directed scenarios, random ops
//            against an array-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_array_engine;
    localparam int DW = 8;
    localparam int MW = 1024;
    localparam int PW = 16;
    localparam int SW = 256;
    localparam int AW = 10;

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_COMMIT = 3'd2;
    localparam logic [2:0] OP_SECTOR = 3'd3;
    localparam logic [2:0] OP_BULK   = 3'd4;
    localparam logic [2:0] OP_STOP   = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flash_array_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    flash_array_engine #(
        .DATA_W(DW), .MEM_WORDS(MW), .PAGE_WORDS(PW), .SECTOR_WORDS(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: flat array, page buffer and load bookkeeping.
    logic [7:0] model [MW];
    logic [7:0] mbuf  [PW];
    int         m_base;
    int         m_idx;
    logic [7:0] wdat  [32];
    logic [7:0] got   [300];

    typedef struct {
        bit         valid;
        logic [2:0] op;
        bit         rd_req;
        bit         wr_valid;
        bit         e_err;
        bit         e_rdv;
        bit         e_busy;
    } vec_t;
    vec_t tv [11];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input int addr);
        int t;
        t = 0;
        while (!bus.cmd_ready && t < 2000) begin
            tick();
            t++;
        end
        if (!bus.cmd_ready) check("cmd_ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = AW'(addr);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n);
        int cyc;
        int rdy;
        cyc = 0;
        rdy = 0;
        while (bus.busy && cyc < n + 8) begin
            if (bus.cmd_ready) rdy++;
            tick();
            cyc++;
        end
        check({name, "_busy_cycles"}, cyc, n);
        check({name, "_ready_while_busy"}, rdy, 0);
        check({name, "_done"}, bus.done, 1);
        check({name, "_ready_after"}, bus.cmd_ready, 1);
    endtask

    task automatic m_erase(input int base, input int n);
        for (int i = 0; i < n; i++) model[(base + i) % MW] = 8'hFF;
    endtask

    task automatic load_page(input int addr, input int n);
        issue(OP_LOAD, addr);
        for (int i = 0; i < PW; i++) mbuf[i] = 8'hFF;
        m_base = addr - (addr % PW);
        m_idx  = addr % PW;
        for (int k = 0; k < n; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wdat[k];
            tick();
            mbuf[m_idx] = wdat[k];
            m_idx = (m_idx + 1) % PW;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic commit(input string name);
        issue(OP_COMMIT, 0);
        wait_done(name, PW);
        for (int i = 0; i < PW; i++) model[m_base + i] = model[m_base + i] & mbuf[i];
    endtask

    task automatic read_range(input string name, input int addr, input int n, input bit chk_ptr);
        issue(OP_READ, addr);
        bus.rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (chk_ptr) check({name, "_rd_ptr"}, int'(dut.rd_ptr), (addr + i) % MW);
            tick();
            check({name, "_rd_valid"}, bus.rd_valid, 1);
            check({name, "_rd_data"}, bus.rd_data, model[(addr + i) % MW]);
            got[i] = bus.rd_data;
        end
        bus.rd_req = 1'b0;
        tick();
        check({name, "_rd_valid_idle"}, bus.rd_valid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int r;
        int a;
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        for (int i = 0; i < MW; i++) model[i] = 8'hFF;

        // Reset values
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_loaded", dut.loaded, 0);
        check("rst_rd_ptr", int'(dut.rd_ptr), 0);
        rst_n = 1'b1;
        tick();

        // Single-cycle vectors: errors, ignored inputs, command-beats-data
        tv[0]  = '{1'b1, OP_COMMIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 3'd5,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 3'd6,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b1, OP_STOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, OP_STOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, OP_STOP,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, OP_READ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, OP_READ,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b1, OP_STOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, OP_STOP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b1, OP_COMMIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int v = 0; v < 11; v++) begin
            bus.cmd_valid = tv[v].valid;
            bus.cmd_op    = tv[v].op;
            bus.cmd_addr  = '0;
            bus.rd_req    = tv[v].rd_req;
            bus.wr_valid  = tv[v].wr_valid;
            tick();
            bus.cmd_valid = 1'b0;
            bus.rd_req    = 1'b0;
            bus.wr_valid  = 1'b0;
            check($sformatf("vec%0d_err", v), bus.err, tv[v].e_err);
            check($sformatf("vec%0d_rd_valid", v), bus.rd_valid, tv[v].e_rdv);
            check($sformatf("vec%0d_busy", v), bus.busy, tv[v].e_busy);
        end
        tick();
        check("err_single_pulse", bus.err, 0);

        // Read wrap across the top of the array
        issue(OP_BULK, 0);
        wait_done("s1_bulk", MW);
        m_erase(0, MW);
        read_range("s1", 'h3FE, 4, 1'b1);
        issue(OP_STOP, 0);
        check("s1_rd_data_cleared", bus.rd_data, 0);

        // Page program with buffer index wrap
        wdat[0] = 8'hA0; wdat[1] = 8'hA1; wdat[2] = 8'hA2;
        load_page('h01E, 3);
        commit("s2_commit");
        read_range("s2", 'h010, 16, 1'b0);
        check("s2_at_010", got[0], 8'hA2);
        check("s2_at_011", got[1], 8'hFF);
        check("s2_at_01E", got[14], 8'hA0);
        check("s2_at_01F", got[15], 8'hA1);

        // AND semantics: bits only clear
        wdat[0] = 8'h0F;
        load_page('h01E, 1);
        commit("s3_commit_a");
        read_range("s3a", 'h01E, 1, 1'b0);
        check("s3_and_0F", got[0], 8'h00);
        wdat[0] = 8'hFF;
        load_page('h01E, 1);
        commit("s3_commit_b");
        read_range("s3b", 'h01E, 1, 1'b0);
        check("s3_stays_00", got[0], 8'h00);

        // Sector erase with a command held pending until done
        wdat[0] = 8'h00; load_page('h155, 1); commit("s4_p155");
        wdat[0] = 8'h5A; load_page('h0FF, 1); commit("s4_p0FF");
        wdat[0] = 8'h3C; load_page('h200, 1); commit("s4_p200");
        issue(OP_SECTOR, 'h1C3);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_STOP;
        wait_done("s4_sector", SW);
        tick();
        bus.cmd_valid = 1'b0;
        m_erase('h100, SW);
        read_range("s4", 'h0FE, 260, 1'b0);
        check("s4_at_0FF", got[1], 8'h5A);
        check("s4_at_155", got[2 + 'h55], 8'hFF);
        check("s4_at_200", got[258], 8'h3C);

        // Randomised operations against the model
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, MW - 1);
            if (r <= 4) begin
                n = $urandom_range(1, 20);
                for (int k = 0; k < n; k++) wdat[k] = 8'($urandom);
                load_page(a, n);
                commit("rnd_commit");
            end else if (r == 5) begin
                issue(OP_SECTOR, a);
                wait_done("rnd_sector", SW);
                m_erase(a - (a % SW), SW);
            end else begin
                read_range("rnd_read", a, $urandom_range(1, 12), 1'b1);
            end
        end

        // Reset in the middle of a bulk erase
        for (int k = 0; k < PW; k++) wdat[k] = 8'h00;
        load_page(0, PW);  commit("s6_p0");
        load_page(16, PW); commit("s6_p1");
        issue(OP_BULK, 0);
        repeat (9) tick();
        check("s6_busy_before_rst", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("s6_busy_in_rst", bus.busy, 0);
        check("s6_done_in_rst", bus.done, 0);
        check("s6_ready_in_rst", bus.cmd_ready, 1);
        tick();
        tick();
        check("s6_no_done", bus.done, 0);
        rst_n = 1'b1;
        tick();
        m_erase(0, 9);
        read_range("s6", 0, 32, 1'b0);
        check("s6_word8", got[8], 8'hFF);
        check("s6_word9", got[9], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
